// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared definitions for the Johnson-counter sequencer: FSM encoding, legal codes and
// the one-hot phase decode.
package johnson_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2,
      StErr  = 2'd3
   } state_e;

   localparam int unsigned JC_STEPS = 8;
   localparam int unsigned JC_W     = 4;

   // Index k holds the code of phase k; concatenation lists the highest index first.
   localparam logic [JC_STEPS-1:0][JC_W-1:0] JC_CODES = {
      4'b0001, 4'b0011, 4'b0111, 4'b1111,
      4'b1110, 4'b1100, 4'b1000, 4'b0000
   };

   localparam logic [JC_W-1:0] JC_LAST = JC_CODES[JC_STEPS-1];

   function automatic logic [JC_STEPS-1:0] jc_phase_oh(input logic [JC_W-1:0] cnt);
      logic [JC_STEPS-1:0] oh;
      oh = '0;
      for (int unsigned k = 0; k < JC_STEPS; k++) begin
         if (cnt == JC_CODES[k]) oh[k] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/johnson_step_core.sv
// 4-bit Johnson counter register with step enable, synchronous clear and a legality flag.
module johnson_step_core
   import johnson_seq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_clr,
   output logic [JC_W-1:0] o_cnt,
   output logic            o_legal
);

   logic [JC_W-1:0] cnt_q, cnt_d;

   // Clear wins over step so an illegal code is never shifted further.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = {~cnt_q[0], cnt_q[JC_W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt   = cnt_q;
   assign o_legal = |jc_phase_oh(cnt_q);

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Runs a Johnson counter for a requested number of 8-step revolutions, with hold, abort
// and an error state for corrupted counter codes.
module johnson_seq_ctrl
   import johnson_seq_ctrl_pkg::*;
#(
   parameter int unsigned REV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [REV_W-1:0] i_rev_cnt,
   input  logic             i_hold,
   input  logic             i_abort,
   output logic [3:0]       o_cnt,
   output logic [7:0]       o_phase_oh,
   output logic [REV_W-1:0] o_rev_left,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   state_e           state_q, state_d;
   logic [REV_W-1:0] rev_q, rev_d;
   logic [JC_W-1:0]  cnt;
   logic             legal;
   logic             step_en;
   logic             step_clr;

   johnson_step_core u_core (
      .clk     (clk),
      .rst     (rst),
      .i_en    (step_en),
      .i_clr   (step_clr),
      .o_cnt   (cnt),
      .o_legal (legal)
   );

   always_comb begin
      state_d  = state_q;
      rev_d    = rev_q;
      step_en  = 1'b0;
      step_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            step_clr = 1'b1;
            if (i_start) begin
               if (i_rev_cnt != '0) begin
                  rev_d   = i_rev_cnt;
                  state_d = StRun;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            // Priority: abort, then corruption, then hold, then normal stepping.
            if (i_abort) begin
               step_clr = 1'b1;
               rev_d    = '0;
               state_d  = StIdle;
            end else if (!legal) begin
               step_clr = 1'b1;
               rev_d    = '0;
               state_d  = StErr;
            end else if (!i_hold) begin
               step_en = 1'b1;
               if (cnt == JC_LAST) begin
                  rev_d = rev_q - REV_W'(1);
                  if (rev_q == REV_W'(1)) state_d = StDone;
               end
            end
         end
         StDone: begin
            step_clr = 1'b1;
            state_d  = StIdle;
         end
         StErr: begin
            step_clr = 1'b1;
            if (i_abort) state_d = StIdle;
         end
         default: begin
            step_clr = 1'b1;
            rev_d    = '0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         rev_q   <= '0;
      end else begin
         state_q <= state_d;
         rev_q   <= rev_d;
      end
   end

   assign o_cnt      = cnt;
   assign o_phase_oh = jc_phase_oh(cnt);
   assign o_rev_left = rev_q;
   assign o_busy     = (state_q == StRun);
   assign o_done     = (state_q == StDone);
   assign o_err      = (state_q == StErr);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: expected per-cycle outputs are queued when a run
// is launched and popped one per clock as the DUT advances.
module tb_johnson_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_rev_cnt = 8'd0;
   logic       i_hold = 1'b0;
   logic       i_abort = 1'b0;
   logic [3:0] o_cnt;
   logic [7:0] o_phase_oh;
   logic [7:0] o_rev_left;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                             4'b1111, 4'b0111, 4'b0011, 4'b0001};

   typedef struct {
      logic [3:0] cnt;
      logic [7:0] oh;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] rev;
   } exp_t;

   exp_t exp_q[$];

   johnson_seq_ctrl #(.REV_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_rev_cnt  (i_rev_cnt),
      .i_hold     (i_hold),
      .i_abort    (i_abort),
      .o_cnt      (o_cnt),
      .o_phase_oh (o_phase_oh),
      .o_rev_left (o_rev_left),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] cnt, input logic [7:0] oh, input logic busy,
                               input logic done, input logic err, input logic [7:0] rev);
      exp_t e;
      e.cnt  = cnt;
      e.oh   = oh;
      e.busy = busy;
      e.done = done;
      e.err  = err;
      e.rev  = rev;
      return e;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, " cnt"},  32'(o_cnt), 32'h0);
      check({tag, " oh"},   32'(o_phase_oh), 32'h01);
      check({tag, " rev"},  32'(o_rev_left), 32'h0);
      check({tag, " busy"}, 32'(o_busy), 32'h0);
      check({tag, " done"}, 32'(o_done), 32'h0);
      check({tag, " err"},  32'(o_err), 32'h0);
   endtask

   // Expected sample after each clock, starting with the edge that accepts the start.
   task automatic exp_run(input int n, input int hold_at, input int hold_len, input int abort_at);
      exp_t it;
      int   idx = 0;
      bit   stop = 1'b0;
      for (int r = n; r >= 1; r--) begin
         for (int k = 0; k < 8; k++) begin
            if (!stop) begin
               it = mk(codes[k], 8'(1) << k, 1'b1, 1'b0, 1'b0, 8'(r));
               exp_q.push_back(it);
               if (idx == abort_at) stop = 1'b1;
               if (idx == hold_at) begin
                  for (int h = 0; h < hold_len; h++) begin
                     exp_q.push_back(it);
                     idx++;
                  end
               end
               idx++;
            end
         end
      end
      if (!stop) exp_q.push_back(mk(4'b0000, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0));
      exp_q.push_back(mk(4'b0000, 8'h01, 1'b0, 1'b0, 1'b0, 8'd0));
      if (stop) exp_q.push_back(mk(4'b0000, 8'h01, 1'b0, 1'b0, 1'b0, 8'd0));
   endtask

   task automatic cmp(input string name, input int i, input exp_t e);
      string t;
      t = $sformatf("%s[%0d]", name, i);
      check({t, " cnt"},  32'(o_cnt), 32'(e.cnt));
      check({t, " oh"},   32'(o_phase_oh), 32'(e.oh));
      check({t, " busy"}, 32'(o_busy), 32'(e.busy));
      check({t, " done"}, 32'(o_done), 32'(e.done));
      check({t, " err"},  32'(o_err), 32'(e.err));
      check({t, " rev"},  32'(o_rev_left), 32'(e.rev));
   endtask

   // Called #1 after a rising edge; noise_at pulses a stray start (count 7) during the run.
   task automatic run(input string name, input int n, input int hold_at, input int hold_len,
                      input int abort_at, input int noise_at);
      exp_t e;
      int   i = 0;
      exp_q.delete();
      exp_run(n, hold_at, hold_len, abort_at);
      i_start   = 1'b1;
      i_rev_cnt = 8'(n);
      while (exp_q.size() != 0 && i < 200) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         cmp(name, i, e);
         i_start   = (i == noise_at);
         i_rev_cnt = (i == noise_at) ? 8'd7 : 8'(n);
         i_hold    = (i >= hold_at) && (i < hold_at + hold_len);
         i_abort   = (i == abort_at);
         i++;
      end
      check({name, " drained"}, 32'(exp_q.size()), 32'h0);
      i_start = 1'b0;
      i_hold  = 1'b0;
      i_abort = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("idle");

      run("n1", 1, -1, 0, -1, -1);
      run("n3hold", 3, 10, 5, -1, -1);
      run("n0", 0, -1, 0, -1, -1);
      run("abort", 2, -1, 0, 15, 5);

      // Corrupt the counter mid-run.
      i_start   = 1'b1;
      i_rev_cnt = 8'd2;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("err pre cnt", 32'(o_cnt), 32'hE);
      @(negedge clk);
      force dut.u_core.cnt_q = 4'b0101;
      #1;
      release dut.u_core.cnt_q;
      check("err forced cnt", 32'(o_cnt), 32'h5);
      check("err forced oh", 32'(o_phase_oh), 32'h0);
      i_start   = 1'b1;
      i_rev_cnt = 8'd3;
      @(posedge clk);
      #1;
      check("err state", 32'(o_err), 32'h1);
      check("err cnt", 32'(o_cnt), 32'h0);
      check("err rev", 32'(o_rev_left), 32'h0);
      check("err busy", 32'(o_busy), 32'h0);
      @(posedge clk);
      #1;
      check("err hold start", 32'(o_err), 32'h1);
      check("err no run", 32'(o_busy), 32'h0);
      i_start = 1'b0;
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
      check("err cleared", 32'(o_err), 32'h0);
      check("err to idle busy", 32'(o_busy), 32'h0);
      check("err to idle cnt", 32'(o_cnt), 32'h0);

      // Asynchronous reset mid-run at 1110.
      i_start   = 1'b1;
      i_rev_cnt = 8'd1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rst pre cnt", 32'(o_cnt), 32'hE);
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("async rst");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("post rst");
      run("after_rst", 1, -1, 0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
